// File: rtl/sw_array_ctrl.sv
// Sequencer for the linear Smith-Waterman PE array: query load, target feed, drain, best-score report.
// Optional SW_CTRL_PERF_EN adds the perf_stall counter of FEED cycles starved by the target source.
module sw_array_ctrl #(
    parameter int NUM_PE    = 64,
    parameter int T_LEN_BIT = 12,
    parameter int SCORE_W   = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [T_LEN_BIT-1:0] t_len,
    output logic                 busy,
    output logic                 done,
    output logic [SCORE_W-1:0]   score,
    input  logic                 q_valid,
    input  logic [1:0]           q_data,
    output logic                 q_ready,
    input  logic                 t_valid,
    input  logic [1:0]           t_data,
    output logic                 t_ready,
    output logic                 q_shift,
    output logic [1:0]           q_sym,
    output logic                 pe_en,
    output logic [1:0]           pe_t,
    output logic                 pe_newline,
    output logic                 pe_valid,
    input  logic [SCORE_W-1:0]   max_in
`ifdef SW_CTRL_PERF_EN
    ,
    output logic [15:0]          perf_stall
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        QLOAD = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        FIN   = 3'd4
    } state_t;

    localparam logic [T_LEN_BIT-1:0] LAST_PE = T_LEN_BIT'(NUM_PE - 1);

    state_t               state;
    logic [T_LEN_BIT-1:0] cnt;
    logic [T_LEN_BIT-1:0] tLenQ;
    logic [SCORE_W-1:0]   best;
    logic [SCORE_W-1:0]   bestNext;
    logic                 enD;

    // Handshakes: a symbol moves on a cycle where both valid and ready are high;
    // ready is a pure function of state, so sources may hold valid across stalls.
    always_comb begin
        q_shift    = (state == QLOAD) && q_valid;
        q_sym      = q_shift ? q_data : 2'b00;
        pe_valid   = (state == FEED) && t_valid;
        pe_en      = pe_valid || (state == DRAIN);
        pe_t       = pe_valid ? t_data : 2'b00;
        pe_newline = pe_valid && (cnt == '0);
    end

    // max_in is registered inside the array, so it reflects the cycle after pe_en.
    always_comb begin
        bestNext = best;
        if (enD && (max_in > best)) begin
            bestNext = max_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            q_ready <= 1'b0;
            t_ready <= 1'b0;
            done    <= 1'b0;
            score   <= '0;
            cnt     <= '0;
            tLenQ   <= '0;
            best    <= '0;
            enD     <= 1'b0;
        end else begin
            done <= 1'b0;
            enD  <= pe_en;
            best <= bestNext;
            case (state)
                IDLE: begin
                    if (start) begin
                        tLenQ <= t_len;
                        best  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        if (t_len == '0) begin
                            state <= FIN;
                        end else begin
                            state   <= QLOAD;
                            q_ready <= 1'b1;
                        end
                    end
                end
                QLOAD: begin
                    if (q_valid) begin
                        if (cnt == LAST_PE) begin
                            cnt     <= '0;
                            state   <= FEED;
                            q_ready <= 1'b0;
                            t_ready <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FEED: begin
                    if (t_valid) begin
                        if (cnt == tLenQ - 1'b1) begin
                            cnt     <= '0;
                            state   <= DRAIN;
                            t_ready <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == LAST_PE) begin
                        cnt   <= '0;
                        state <= FIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIN: begin
                    score <= bestNext;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    q_ready <= 1'b0;
                    t_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef SW_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall <= '0;
        end else if ((state == IDLE) && start) begin
            perf_stall <= '0;
        end else if ((state == FEED) && !t_valid && (perf_stall != 16'hFFFF)) begin
            perf_stall <= perf_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sw_array_ctrl.sv
// Self-checking bench for sw_array_ctrl: phase-level reference model feeding per-cycle and per-job expectation queues.
module tb_sw_array_ctrl;
    localparam int NUM_PE    = 4;
    localparam int T_LEN_BIT = 12;
    localparam int SCORE_W   = 10;
    localparam int MAX_CYC   = 60000;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [T_LEN_BIT-1:0] t_len;
    logic                 busy;
    logic                 done;
    logic [SCORE_W-1:0]   score;
    logic                 q_valid;
    logic [1:0]           q_data;
    logic                 q_ready;
    logic                 t_valid;
    logic [1:0]           t_data;
    logic                 t_ready;
    logic                 q_shift;
    logic [1:0]           q_sym;
    logic                 pe_en;
    logic [1:0]           pe_t;
    logic                 pe_newline;
    logic                 pe_valid;
    logic [SCORE_W-1:0]   max_in;
`ifdef SW_CTRL_PERF_EN
    logic [15:0]          perf_stall;
`endif

    sw_array_ctrl #(
        .NUM_PE   (NUM_PE),
        .T_LEN_BIT(T_LEN_BIT),
        .SCORE_W  (SCORE_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .t_len     (t_len),
        .busy      (busy),
        .done      (done),
        .score     (score),
        .q_valid   (q_valid),
        .q_data    (q_data),
        .q_ready   (q_ready),
        .t_valid   (t_valid),
        .t_data    (t_data),
        .t_ready   (t_ready),
        .q_shift   (q_shift),
        .q_sym     (q_sym),
        .pe_en     (pe_en),
        .pe_t      (pe_t),
        .pe_newline(pe_newline),
        .pe_valid  (pe_valid),
        .max_in    (max_in)
`ifdef SW_CTRL_PERF_EN
        ,
        .perf_stall(perf_stall)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(MAX_CYC * 10);
        $display("FAIL watchdog: run exceeded %0d cycles", MAX_CYC);
        $fatal(1, "watchdog expired");
    end

    // Expected per-cycle outputs
    typedef struct packed {
        logic               busy;
        logic               q_ready;
        logic               t_ready;
        logic               q_shift;
        logic [1:0]         q_sym;
        logic               pe_en;
        logic               pe_valid;
        logic               pe_newline;
        logic [1:0]         pe_t;
        logic [SCORE_W-1:0] score;
        logic [15:0]        perf;
    } ctrl_t;

    ctrl_t              ctrl_q[$];
    logic [SCORE_W-1:0] exp_q[$];
    int                 exp_cyc_q[$];
    logic [SCORE_W-1:0] max_script[$];

    int                 checks = 0;
    int                 errors = 0;

    // Reference model state
    logic [SCORE_W-1:0] held_score = '0;
    logic [SCORE_W-1:0] best_m = '0;
    int                 perf_m = 0;
    bit                 prev_en = 1'b0;
    bit                 rand_max = 1'b1;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        ctrl_t e;
        if (ctrl_q.size() > 0) begin
            e = ctrl_q.pop_front();
            check_eq("busy", 32'(busy), 32'(e.busy));
            check_eq("q_ready", 32'(q_ready), 32'(e.q_ready));
            check_eq("t_ready", 32'(t_ready), 32'(e.t_ready));
            check_eq("q_shift", 32'(q_shift), 32'(e.q_shift));
            check_eq("q_sym", 32'(q_sym), 32'(e.q_sym));
            check_eq("pe_en", 32'(pe_en), 32'(e.pe_en));
            check_eq("pe_valid", 32'(pe_valid), 32'(e.pe_valid));
            check_eq("pe_newline", 32'(pe_newline), 32'(e.pe_newline));
            check_eq("pe_t", 32'(pe_t), 32'(e.pe_t));
            check_eq("score_held", 32'(score), 32'(e.score));
`ifdef SW_CTRL_PERF_EN
            check_eq("perf_stall", 32'(perf_stall), 32'(e.perf));
`endif
        end
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
            end else begin
                check_eq("done_score", 32'(score), 32'(exp_q.pop_front()));
                check_eq("done_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
            end
        end
    end

    // Driver tasks
    task automatic new_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic ctrl_t base_exp();
        ctrl_t e;
        e       = '0;
        e.score = held_score;
        e.perf  = perf_m[15:0];
        return e;
    endfunction

    task automatic noise();
        q_data  = 2'($urandom_range(0, 3));
        t_data  = 2'($urandom_range(0, 3));
        q_valid = 1'($urandom_range(0, 1));
        t_valid = 1'($urandom_range(0, 1));
        t_len   = T_LEN_BIT'($urandom_range(0, 4095));
    endtask

    // Chooses this cycle's max_in and folds it into the best score when it is a sample cycle.
    task automatic set_max();
        if (prev_en && max_script.size() > 0) begin
            max_in = max_script.pop_front();
        end else if (!rand_max) begin
            max_in = '0;
        end else if ($urandom_range(0, 7) == 0) begin
            max_in = best_m;
        end else if ($urandom_range(0, 3) == 0) begin
            max_in = SCORE_W'($urandom_range(0, 1023));
        end else begin
            max_in = SCORE_W'($urandom_range(0, 200));
        end
        if (prev_en && max_in > best_m) best_m = max_in;
    endtask

    task automatic idle_cycle();
        new_cycle();
        rst   = 1'b0;
        start = 1'b0;
        noise();
        set_max();
        ctrl_q.push_back(base_exp());
        prev_en = 1'b0;
    endtask

    task automatic reset_cycle();
        new_cycle();
        rst   = 1'b1;
        start = 1'($urandom_range(0, 1));
        noise();
        set_max();
        ctrl_q.push_back(base_exp());
        held_score = '0;
        perf_m     = 0;
        prev_en    = 1'b0;
    endtask

    // qmode: 0 always valid, 1 pattern 1,0,1,1,0,1, 2 random.
    // tmode: 0 always valid, 1 two stalls after the first symbol, 2 random.
    task automatic run_job(input int tlen, input int qmode, input int tmode, input int abort_at);
        ctrl_t e;
        int    acc;
        int    k;
        bit    v;
        bit    qpat[6];
        qpat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        new_cycle();
        rst = 1'b0;
        noise();
        start = 1'b1;
        t_len = T_LEN_BIT'(tlen);
        set_max();
        ctrl_q.push_back(base_exp());
        prev_en = 1'b0;
        best_m  = '0;
        perf_m  = 0;

        if (tlen != 0) begin
            acc = 0;
            k   = 0;
            while (acc < NUM_PE) begin
                new_cycle();
                noise();
                start = 1'($urandom_range(0, 1));
                v = (qmode == 0) ? 1'b1 : (qmode == 1) ? qpat[k % 6] : ($urandom_range(0, 2) != 0);
                q_valid = v;
                set_max();
                e         = base_exp();
                e.busy    = 1'b1;
                e.q_ready = 1'b1;
                e.q_shift = v;
                e.q_sym   = v ? q_data : 2'b00;
                ctrl_q.push_back(e);
                if (v) acc++;
                prev_en = 1'b0;
                k++;
            end

            acc = 0;
            k   = 0;
            while (acc < tlen) begin
                new_cycle();
                noise();
                start = 1'($urandom_range(0, 1));
                v = (tmode == 0) ? 1'b1 : (tmode == 1) ? !(k == 1 || k == 2) : ($urandom_range(0, 3) != 0);
                t_valid = v;
                set_max();
                e            = base_exp();
                e.busy       = 1'b1;
                e.t_ready    = 1'b1;
                e.pe_en      = v;
                e.pe_valid   = v;
                e.pe_newline = v && (acc == 0);
                e.pe_t       = v ? t_data : 2'b00;
                ctrl_q.push_back(e);
                if (v) acc++;
                else if (perf_m < 65535) perf_m++;
                prev_en = v;
                k++;
            end

            for (int i = 0; i < NUM_PE; i++) begin
                new_cycle();
                noise();
                start = 1'($urandom_range(0, 1));
                rst   = (i == abort_at);
                set_max();
                e       = base_exp();
                e.busy  = 1'b1;
                e.pe_en = 1'b1;
                ctrl_q.push_back(e);
                prev_en = 1'b1;
                if (i == abort_at) begin
                    held_score = '0;
                    perf_m     = 0;
                    prev_en    = 1'b0;
                    return;
                end
            end
        end

        new_cycle();
        noise();
        start = 1'($urandom_range(0, 1));
        set_max();
        e      = base_exp();
        e.busy = 1'b1;
        ctrl_q.push_back(e);
        exp_q.push_back(best_m);
        exp_cyc_q.push_back(cyc + 1);
        held_score = best_m;
        prev_en    = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        t_len   = '0;
        q_valid = 1'b0;
        q_data  = '0;
        t_valid = 1'b0;
        t_data  = '0;
        max_in  = '0;

        reset_cycle();
        reset_cycle();
        repeat (2) idle_cycle();

        // Unstalled run with a known max_in ramp
        rand_max = 1'b0;
        max_script = '{10'd1, 10'd2, 10'd5, 10'd3};
        run_job(3, 0, 0, -1);
        repeat (3) idle_cycle();

        // Same job with a two-cycle target stall
        max_script = '{10'd1, 10'd2, 10'd5, 10'd3};
        run_job(3, 0, 1, -1);
        repeat (2) idle_cycle();

        // Empty target
        rand_max = 1'b1;
        run_job(0, 2, 2, -1);
        repeat (2) idle_cycle();

        // Reset while draining, then a normal job
        run_job(5, 2, 2, 1);
        repeat (2) idle_cycle();
        run_job(3, 1, 0, -1);
        repeat (2) idle_cycle();

        // Randomized jobs, some started in the done cycle
        for (int j = 0; j < 12; j++) begin
            run_job($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 20),
                    $urandom_range(0, 2), $urandom_range(0, 2), -1);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) idle_cycle();
        end

        // Full-count target length
        run_job(4095, 0, 2, -1);
        repeat (4) idle_cycle();

        check_eq("pending_done", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
